stack_engine: RTL and testbench
===============================

STACK_ENGINE -- requirements
Module: stack_engine

Interface
REQ-001 Parameter STACK_TOP, default 16'hBFFF, SP value of an empty stack; pop is refused at this value.
REQ-002 Parameter STACK_LIMIT, default 16'h8000, lowest legal SP; push is refused at this value.
REQ-003 Parameter SP_ADDR, default 4'hD, register-file address of SP.
REQ-004 clock  in  1  sole clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low; asserting it forces the reset state immediately.
REQ-006 cmd_valid  in  1  request present.
REQ-007 cmd_op  in  1  0 = push, 1 = pop.
REQ-008 cmd_reg  in  4  source register for push, destination register for pop.
REQ-009 cmd_ready  out  1  high only in IDLE; a command is accepted on an edge with cmd_valid && cmd_ready.
REQ-010 done  out  1  one-cycle pulse in the final cycle of every accepted command.
REQ-011 fault  out  1  qualifies done; high only with done, when the command was refused.
REQ-012 rf_read_addr  out  4  register-file read port address.
REQ-013 rf_read_data  in  16  combinational read data for rf_read_addr.
REQ-014 rf_sp  in  16  current SP value, from a dedicated register-file read port tied to SP_ADDR.
REQ-015 rf_write_addr / rf_write_data / rf_write_en  out  4/16/1  register-file write port, committed on the rising edge.
REQ-016 mem_addr / mem_wdata / mem_wen / mem_ren  out  16/16/1/1  data memory port.
REQ-017 mem_rdata  in  16  valid exactly one cycle after the cycle in which mem_ren is high.

Function
REQ-018 The FSM SHALL have the states IDLE, FETCH, MEM_WR, MEM_RD, MEM_WAIT, REG_WR and SP_UPD.
REQ-019 On acceptance, the block SHALL latch cmd_op and cmd_reg; IDLE -> FETCH.
REQ-020 FETCH: rf_read_addr = latched reg; latch rf_read_data as operand and rf_sp as sp_q.
REQ-021 FETCH, push, sp_q == STACK_LIMIT: done=1 and fault=1, no memory or register write, next state IDLE (overflow).
REQ-022 FETCH, pop, sp_q == STACK_TOP: done=1 and fault=1, no side effects, next state IDLE (underflow).
REQ-023 Push path: FETCH -> MEM_WR (mem_wen=1, mem_addr=sp_q, mem_wdata=operand) -> SP_UPD.
REQ-024 Pop path: FETCH -> MEM_RD (mem_ren=1, mem_addr=sp_q+1) -> MEM_WAIT (latch mem_rdata) -> REG_WR -> SP_UPD.
REQ-025 REG_WR SHALL drive rf_write_en=1, rf_write_addr=latched reg, rf_write_data=popped value.
REQ-026 SP_UPD SHALL drive rf_write_en=1, rf_write_addr=SP_ADDR, rf_write_data=sp_q-1 for push or sp_q+1 for pop, done=1; next state IDLE.
REQ-027 SP arithmetic SHALL be 16-bit modulo; legal parameters never wrap.
REQ-028 Pop with latched reg == SP_ADDR SHALL write the popped value in REG_WR, skip SP_UPD, and assert done in REG_WR.
REQ-029 Pop with latched reg 4'hE or 4'hF SHALL still perform REG_WR, which the register file discards, and update SP normally; there is no fault.
REQ-030 Push with latched reg == SP_ADDR SHALL store the pre-decrement SP.
REQ-031 Latency from the accept edge to the done cycle SHALL be: push 3 cycles; pop 5 cycles (4 when the destination is SP); fault 1 cycle.
REQ-032 cmd_ready SHALL be low in every non-IDLE state; the next command can be accepted in the cycle after done.
REQ-033 Outside the stated states, mem_wen, mem_ren, rf_write_en, done and fault SHALL be 0.

Reset
REQ-034 While reset is low: state = IDLE; done, fault, mem_wen, mem_ren and rf_write_en = 0; cmd_ready = 1; all latched data = 0.
REQ-035 Reset asserted mid-command SHALL abandon the command with no further writes; SP is left at its last committed value.

Verification
REQ-036 SP=BFFF, R3=1234, push R3 -> mem[BFFF]=1234, SP=BFFE, done 3 cycles after accept, fault=0.
REQ-037 After REQ-036, pop R5 -> mem_ren at addr BFFF, R5=1234, SP=BFFF, done 5 cycles after accept.
REQ-038 SP=BFFF, pop R1 -> done=fault=1 one cycle after accept, no writes, R1 and SP unchanged.
REQ-039 SP=8000, push R0 -> done=fault=1, no mem_wen, SP stays 8000.
REQ-040 SP=BFFE, mem[BFFF]=BEEF, pop into SP_ADDR -> SP=BEEF, no SP_UPD write, done 4 cycles after accept.
REQ-041 Push accepted, reset pulsed low in MEM_WR -> all strobes drop immediately, SP unchanged, cmd_ready=1 after release.

Source files
------------

// File: rtl/stack_engine.sv
// Push/pop engine that moves words between the register file and a descending
// stack in data memory, keeping the stack pointer in the register file.
module stack_engine #(
  parameter logic [15:0] STACK_TOP   = 16'hBFFF,
  parameter logic [15:0] STACK_LIMIT = 16'h8000,
  parameter logic [3:0]  SP_ADDR     = 4'hD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic        cmd_op,
  input  logic [3:0]  cmd_reg,
  output logic        cmd_ready,
  output logic        done,
  output logic        fault,
  output logic [3:0]  rf_read_addr,
  input  logic [15:0] rf_read_data,
  input  logic [15:0] rf_sp,
  output logic [3:0]  rf_write_addr,
  output logic [15:0] rf_write_data,
  output logic        rf_write_en,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_wen,
  output logic        mem_ren,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, FETCH, MEM_WR, MEM_RD, MEM_WAIT, REG_WR, SP_UPD
  } state_t;

  state_t      state, next_state;
  logic        op_q;
  logic [3:0]  reg_q;
  logic [15:0] operand_q;
  logic [15:0] sp_q;
  logic [15:0] popped_q;
  logic        refused;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // The SP port is sampled live in FETCH, so the bounds check cannot wait for sp_q.
  assign refused      = op_q ? (rf_sp == STACK_TOP) : (rf_sp == STACK_LIMIT);
  assign rf_read_addr = reg_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q      <= 1'b0;
      reg_q     <= 4'h0;
      operand_q <= 16'h0000;
      sp_q      <= 16'h0000;
      popped_q  <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            reg_q <= cmd_reg;
          end
        end
        FETCH: begin
          operand_q <= rf_read_data;
          sp_q      <= rf_sp;
        end
        MEM_WAIT: popped_q <= mem_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state    = state;
    cmd_ready     = 1'b0;
    done          = 1'b0;
    fault         = 1'b0;
    mem_wen       = 1'b0;
    mem_ren       = 1'b0;
    mem_addr      = 16'h0000;
    mem_wdata     = 16'h0000;
    rf_write_en   = 1'b0;
    rf_write_addr = 4'h0;
    rf_write_data = 16'h0000;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) next_state = FETCH;
      end
      FETCH: begin
        if (refused) begin
          done       = 1'b1;
          fault      = 1'b1;
          next_state = IDLE;
        end else begin
          next_state = op_q ? MEM_RD : MEM_WR;
        end
      end
      MEM_WR: begin
        mem_wen    = 1'b1;
        mem_addr   = sp_q;
        mem_wdata  = operand_q;
        next_state = SP_UPD;
      end
      MEM_RD: begin
        mem_ren    = 1'b1;
        mem_addr   = sp_q + 16'd1;
        next_state = MEM_WAIT;
      end
      MEM_WAIT: next_state = REG_WR;
      REG_WR: begin
        rf_write_en   = 1'b1;
        rf_write_addr = reg_q;
        rf_write_data = popped_q;
        // Popping into SP itself makes the popped word the new SP, so no increment follows.
        if (reg_q == SP_ADDR) begin
          done       = 1'b1;
          next_state = IDLE;
        end else begin
          next_state = SP_UPD;
        end
      end
      SP_UPD: begin
        rf_write_en   = 1'b1;
        rf_write_addr = SP_ADDR;
        rf_write_data = op_q ? (sp_q + 16'd1) : (sp_q - 16'd1);
        done          = 1'b1;
        next_state    = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stack_engine.sv
// Self-checking bench for stack_engine with behavioural register-file and memory models.
module tb_stack_engine;

  localparam logic [3:0] SP_ADDR = 4'hD;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_op = 1'b0;
  logic [3:0]  cmd_reg = 4'h0;
  logic        cmd_ready, done, fault;
  logic [3:0]  rf_read_addr, rf_write_addr;
  logic [15:0] rf_read_data, rf_sp, rf_write_data;
  logic        rf_write_en;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_wen, mem_ren;
  logic [15:0] mem_rdata = 16'h0000;

  logic [15:0] regs [0:15];
  logic [15:0] mem  [0:65535];

  logic        bd_rf_we = 1'b0;
  logic [3:0]  bd_rf_addr = 4'h0;
  logic [15:0] bd_rf_data = 16'h0000;
  logic        bd_mem_we = 1'b0;
  logic [15:0] bd_mem_addr = 16'h0000;
  logic [15:0] bd_mem_data = 16'h0000;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int   lat;
    logic flt;
    int   memw;
    int   memr;
    int   rfw;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] last_ren_addr;

  stack_engine dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_ready(cmd_ready),
    .done(done), .fault(fault),
    .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data), .rf_sp(rf_sp),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data), .rf_write_en(rf_write_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  assign rf_read_data = regs[rf_read_addr];
  assign rf_sp        = regs[SP_ADDR];

  // Register file: addresses E and F are not writable.
  always @(posedge clock) begin
    if (bd_rf_we) regs[bd_rf_addr] <= bd_rf_data;
    else if (rf_write_en && rf_write_addr < 4'hE) regs[rf_write_addr] <= rf_write_data;
  end

  always @(posedge clock) begin
    if (bd_mem_we) mem[bd_mem_addr] <= bd_mem_data;
    else if (mem_wen) mem[mem_addr] <= mem_wdata;
    if (mem_ren) mem_rdata <= mem[mem_addr];
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic set_reg(input logic [3:0] a, input logic [15:0] d);
    @(negedge clock);
    bd_rf_we = 1'b1; bd_rf_addr = a; bd_rf_data = d;
    @(negedge clock);
    bd_rf_we = 1'b0;
  endtask

  task automatic set_mem(input logic [15:0] a, input logic [15:0] d);
    @(negedge clock);
    bd_mem_we = 1'b1; bd_mem_addr = a; bd_mem_data = d;
    @(negedge clock);
    bd_mem_we = 1'b0;
  endtask

  task automatic run_cmd(input string name, input logic op, input logic [3:0] r,
                         input int lat, input logic flt, input int memw, input int memr, input int rfw);
    exp_t e, got_e;
    int   cycles;
    int   waits;
    logic got;
    e.lat = lat; e.flt = flt; e.memw = memw; e.memr = memr; e.rfw = rfw;
    exp_q.push_back(e);
    @(negedge clock);
    waits = 0;
    while (!cmd_ready && waits < 20) begin
      @(negedge clock);
      waits++;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_reg = r;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    cycles = 0; got = 1'b0;
    got_e.lat = 0; got_e.flt = 1'b0; got_e.memw = 0; got_e.memr = 0; got_e.rfw = 0;
    while (!got && cycles < 20) begin
      @(negedge clock);
      cycles++;
      if (mem_wen) got_e.memw++;
      if (mem_ren) begin
        got_e.memr++;
        last_ren_addr = mem_addr;
      end
      if (rf_write_en) got_e.rfw++;
      if (done) begin
        got = 1'b1;
        got_e.lat = cycles;
        got_e.flt = fault;
      end
    end
    e = exp_q.pop_front();
    compared++;
    if (!got) begin
      mismatched++;
      $display("[TB] FAIL %s done timeout: got none in %0d cycles, expected at %0d", name, cycles, e.lat);
    end else begin
      compared += 5;
      if (got_e.lat !== e.lat) begin
        mismatched++;
        $display("[TB] FAIL %s latency: got %0d, expected %0d", name, got_e.lat, e.lat);
      end
      if (got_e.flt !== e.flt) begin
        mismatched++;
        $display("[TB] FAIL %s fault: got %0b, expected %0b", name, got_e.flt, e.flt);
      end
      if (got_e.memw !== e.memw) begin
        mismatched++;
        $display("[TB] FAIL %s mem_wen cycles: got %0d, expected %0d", name, got_e.memw, e.memw);
      end
      if (got_e.memr !== e.memr) begin
        mismatched++;
        $display("[TB] FAIL %s mem_ren cycles: got %0d, expected %0d", name, got_e.memr, e.memr);
      end
      if (got_e.rfw !== e.rfw) begin
        mismatched++;
        $display("[TB] FAIL %s rf_write_en cycles: got %0d, expected %0d", name, got_e.rfw, e.rfw);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_val("reset cmd_ready", {15'd0, cmd_ready}, 16'h0001);
    check_val("reset strobes", {11'd0, done, fault, mem_wen, mem_ren, rf_write_en}, 16'h0000);
    reset = 1'b1;
    @(negedge clock);
    check_val("post-reset cmd_ready", {15'd0, cmd_ready}, 16'h0001);
  endtask

  task automatic test_push();
    set_reg(SP_ADDR, 16'hBFFF);
    set_reg(4'h3, 16'h1234);
    run_cmd("push R3", 1'b0, 4'h3, 3, 1'b0, 1, 0, 1);
    @(negedge clock);
    check_val("push mem[BFFF]", mem[16'hBFFF], 16'h1234);
    check_val("push SP", regs[SP_ADDR], 16'hBFFE);
  endtask

  task automatic test_pop();
    set_reg(4'h5, 16'h0000);
    run_cmd("pop R5", 1'b1, 4'h5, 5, 1'b0, 0, 1, 2);
    @(negedge clock);
    check_val("pop read addr", last_ren_addr, 16'hBFFF);
    check_val("pop R5", regs[5], 16'h1234);
    check_val("pop SP", regs[SP_ADDR], 16'hBFFF);
  endtask

  task automatic test_underflow();
    set_reg(SP_ADDR, 16'hBFFF);
    set_reg(4'h1, 16'h1111);
    run_cmd("underflow pop R1", 1'b1, 4'h1, 1, 1'b1, 0, 0, 0);
    @(negedge clock);
    check_val("underflow R1", regs[1], 16'h1111);
    check_val("underflow SP", regs[SP_ADDR], 16'hBFFF);
  endtask

  task automatic test_overflow();
    set_reg(SP_ADDR, 16'h8000);
    set_reg(4'h0, 16'hA5A5);
    set_mem(16'h8000, 16'h0000);
    run_cmd("overflow push R0", 1'b0, 4'h0, 1, 1'b1, 0, 0, 0);
    @(negedge clock);
    check_val("overflow SP", regs[SP_ADDR], 16'h8000);
    check_val("overflow mem[8000]", mem[16'h8000], 16'h0000);
  endtask

  task automatic test_pop_to_sp();
    set_reg(SP_ADDR, 16'hBFFE);
    set_mem(16'hBFFF, 16'hBEEF);
    run_cmd("pop SP", 1'b1, SP_ADDR, 4, 1'b0, 0, 1, 1);
    @(negedge clock);
    check_val("pop SP value", regs[SP_ADDR], 16'hBEEF);
  endtask

  task automatic test_push_sp_and_discard();
    set_reg(SP_ADDR, 16'hA000);
    run_cmd("push SP", 1'b0, SP_ADDR, 3, 1'b0, 1, 0, 1);
    @(negedge clock);
    check_val("push SP stored", mem[16'hA000], 16'hA000);
    check_val("push SP new SP", regs[SP_ADDR], 16'h9FFF);
    run_cmd("pop RE", 1'b1, 4'hE, 5, 1'b0, 0, 1, 2);
    @(negedge clock);
    check_val("pop RE SP", regs[SP_ADDR], 16'hA000);
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [3];
    set_reg(SP_ADDR, 16'hBFFF);
    for (int i = 0; i < 3; i++) begin
      vals[i] = 16'($urandom);
      set_reg(4'(i + 1), vals[i]);
    end
    for (int i = 0; i < 3; i++) run_cmd("b2b push", 1'b0, 4'(i + 1), 3, 1'b0, 1, 0, 1);
    for (int i = 0; i < 3; i++) run_cmd("b2b pop", 1'b1, 4'(i + 6), 5, 1'b0, 0, 1, 2);
    @(negedge clock);
    check_val("b2b R6", regs[6], vals[2]);
    check_val("b2b R7", regs[7], vals[1]);
    check_val("b2b R8", regs[8], vals[0]);
    check_val("b2b SP", regs[SP_ADDR], 16'hBFFF);
  endtask

  task automatic test_reset_mid();
    set_reg(SP_ADDR, 16'hBFFF);
    set_reg(4'h2, 16'h5555);
    set_mem(16'hBFFF, 16'h0000);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_reg = 4'h2;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_val("mid mem_wen before reset", {15'd0, mem_wen}, 16'h0001);
    reset = 1'b0;
    #1;
    check_val("mid strobes in reset", {11'd0, done, fault, mem_wen, mem_ren, rf_write_en}, 16'h0000);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_val("mid cmd_ready", {15'd0, cmd_ready}, 16'h0001);
    check_val("mid SP", regs[SP_ADDR], 16'hBFFF);
    check_val("mid mem[BFFF]", mem[16'hBFFF], 16'h0000);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
    test_reset();
    test_push();
    test_pop();
    test_underflow();
    test_overflow();
    test_pop_to_sp();
    test_push_sp_and_discard();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
